// File: rtl/if_fetch_if.sv
// Instruction-memory port of the fetch stage: single-outstanding req/ack.
// The fetch stage is the master; the instruction memory is the slave.
interface if_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage. Owns the PC, issues one fetch at a time on the
// imem port, and queues fetched {pc,inst} pairs for ID. A flush redirects
// the PC, empties the queue and discards any fetch still in flight (an
// un-acked request is completed in DROP and its data thrown away).
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bbl,
  input  logic              flush,
  input  logic [31:0]       flush_pc,
  if_fetch_if.master        imem,
  output logic              id_valid,
  output logic [31:0]       id_inst,
  output logic [31:0]       id_pc,
  output logic              stop
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [31:0]   pc_reg, pc_next;
  logic [31:0]   drop_addr_reg, drop_addr_next;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_pp;
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [31:0]   q_pc   [QDEPTH];
  logic [31:0]   q_inst [QDEPTH];

  logic [31:0]   flush_target;
  logic          push;
  logic          pop;

  // Redirect target is always word aligned; the low bits are simply masked.
  assign flush_target = flush_pc & ~32'h0000_0003;

  // Queue traffic this cycle. flush overrides both push and pop.
  assign push     = (state_reg == S_WAIT) && imem.imem_ack && !flush;
  assign pop      = id_valid && !bbl && !flush;
  assign count_pp = count_reg + CW'(push) - CW'(pop);

  // Next-state, next-PC and drop-address logic of the fetch FSM.
  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    drop_addr_next = drop_addr_reg;
    case (state_reg)
      S_IDLE: begin
        if (flush) begin
          pc_next = flush_target;
        end else if (count_reg < QFULL) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          pc_next = flush_target;
          if (imem.imem_ack) begin
            state_next = S_IDLE;
          end else begin
            // Request cannot be withdrawn: keep presenting the old
            // address until the memory answers, then discard the word.
            state_next     = S_DROP;
            drop_addr_next = pc_reg;
          end
        end else if (imem.imem_ack) begin
          pc_next = pc_reg + 32'd4;
          if (count_pp >= QFULL) begin
            state_next = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (flush) begin
          pc_next = flush_target;
        end
        if (imem.imem_ack) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FSM state, PC and in-flight address registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      pc_reg        <= RESET_PC;
      drop_addr_reg <= 32'h0000_0000;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      drop_addr_reg <= drop_addr_next;
    end
  end

  assign imem.imem_req  = (state_reg != S_IDLE);
  assign imem.imem_addr = (state_reg == S_DROP) ? drop_addr_reg : pc_reg;

  // Queue pointers and occupancy; flush empties the queue.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      count_reg <= count_pp;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
    end
  end

  // Queue storage: each entry captures {pc,inst} when it is the write target.
  generate
    for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_entry
      // Entry write on push; contents are only visible through id_valid.
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == PW'(gi))) begin
          q_pc[gi]   <= pc_reg;
          q_inst[gi] <= imem.imem_rdata;
        end
      end
    end
  endgenerate

  assign id_valid = (count_reg != '0);
  assign id_inst  = id_valid ? q_inst[rd_ptr_reg] : 32'h0000_0000;
  assign id_pc    = id_valid ? q_pc[rd_ptr_reg]   : 32'h0000_0000;
  assign stop     = ~id_valid;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: reset, streaming, bubble hold, flush cases,
// PC wrap and reset in mid-fetch.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        bbl;
  logic        flush;
  logic [31:0] flush_pc;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        stop;

  // Memory control: zw=1 gives a zero-wait memory answering every request
  // with addr+32'h1000_0000; zw=0 uses the manually driven ack/data.
  logic        zw;
  logic        ack_man;
  logic [31:0] rdata_man;

  int n_checks;
  int n_pass;

  if_fetch_if mif ();

  if_fetch #(
    .RESET_PC(32'h0000_0000),
    .QDEPTH  (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bbl     (bbl),
    .flush   (flush),
    .flush_pc(flush_pc),
    .imem    (mif),
    .id_valid(id_valid),
    .id_inst (id_inst),
    .id_pc   (id_pc),
    .stop    (stop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    mif.imem_ack   = zw ? mif.imem_req : ack_man;
    mif.imem_rdata = zw ? (mif.imem_addr + 32'h1000_0000) : rdata_man;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    zw = 1'b0; ack_man = 1'b1; rdata_man = 32'hBAD0_0000;
    bbl = 1'b0; flush = 1'b0; flush_pc = 32'h0; rst = 1'b0;
    tick(); tick();
    n_checks++; if (mif.imem_req !== 1'b0) $display("FAIL reset_req got=%b exp=0", mif.imem_req); else n_pass++;
    n_checks++; if (id_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", id_valid); else n_pass++;
    n_checks++; if (id_inst !== 32'h0) $display("FAIL reset_inst got=%h exp=0", id_inst); else n_pass++;
    n_checks++; if (id_pc !== 32'h0) $display("FAIL reset_pc got=%h exp=0", id_pc); else n_pass++;
    n_checks++; if (stop !== 1'b1) $display("FAIL reset_stop got=%b exp=1", stop); else n_pass++;
    ack_man = 1'b0;
    rst = 1'b1;
    tick();
    n_checks++; if (mif.imem_req !== 1'b1 || mif.imem_addr !== 32'h0)
      $display("FAIL first_req got req=%b addr=%h exp req=1 addr=00000000", mif.imem_req, mif.imem_addr); else n_pass++;
    ack_man = 1'b1; rdata_man = 32'h2401_0005;
    tick();
    ack_man = 1'b0;
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_inst !== 32'h2401_0005 || stop !== 1'b0)
      $display("FAIL first_data got v=%b pc=%h inst=%h stop=%b exp v=1 pc=0 inst=24010005 stop=0",
               id_valid, id_pc, id_inst, stop); else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_stream();
    zw = 1'b1; bbl = 1'b0; flush = 1'b0;
    do_reset();
    tick();  // IDLE -> WAIT
    for (int k = 0; k < 8; k++) begin
      tick();
      n_checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'(4 * k) || id_inst !== 32'(4 * k) + 32'h1000_0000)
        $display("FAIL stream_%0d got v=%b pc=%h inst=%h exp v=1 pc=%h", k, id_valid, id_pc, id_inst, 32'(4 * k));
      else n_pass++;
    end
    $display("test_stream done");
  endtask

  task automatic test_bbl();
    zw = 1'b1; bbl = 1'b0; flush = 1'b0;
    do_reset();
    tick();  // WAIT
    tick();  // head = pc 0
    bbl = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (mif.imem_req !== 1'b0 || id_valid !== 1'b1 || id_pc !== 32'h0)
        $display("FAIL bbl_hold_%0d got req=%b v=%b pc=%h exp req=0 v=1 pc=0", k, mif.imem_req, id_valid, id_pc);
      else n_pass++;
    end
    bbl = 1'b0;
    tick();
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h4)
      $display("FAIL bbl_resume0 got v=%b pc=%h exp v=1 pc=4", id_valid, id_pc); else n_pass++;
    tick();
    n_checks++; if (id_valid !== 1'b0 || mif.imem_req !== 1'b1 || mif.imem_addr !== 32'h8)
      $display("FAIL bbl_refetch got v=%b req=%b addr=%h exp v=0 req=1 addr=8", id_valid, mif.imem_req, mif.imem_addr);
    else n_pass++;
    tick();
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h8)
      $display("FAIL bbl_resume1 got v=%b pc=%h exp v=1 pc=8", id_valid, id_pc); else n_pass++;
    tick();
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'hC)
      $display("FAIL bbl_resume2 got v=%b pc=%h exp v=1 pc=c", id_valid, id_pc); else n_pass++;
    $display("test_bbl done");
  endtask

  task automatic test_flush_drop();
    zw = 1'b0; ack_man = 1'b0; bbl = 1'b0; flush = 1'b0;
    do_reset();
    tick();  // WAIT at 0
    flush = 1'b1; flush_pc = 32'h0000_0100;
    tick();  // -> DROP
    flush = 1'b0;
    n_checks++; if (mif.imem_req !== 1'b1 || mif.imem_addr !== 32'h0 || stop !== 1'b1)
      $display("FAIL drop_hold got req=%b addr=%h stop=%b exp req=1 addr=0 stop=1", mif.imem_req, mif.imem_addr, stop);
    else n_pass++;
    tick();
    ack_man = 1'b1; rdata_man = 32'hDEAD_BEEF;
    tick();  // stale word discarded
    ack_man = 1'b0;
    n_checks++; if (mif.imem_req !== 1'b0 || id_valid !== 1'b0 || stop !== 1'b1)
      $display("FAIL drop_discard got req=%b v=%b stop=%b exp req=0 v=0 stop=1", mif.imem_req, id_valid, stop);
    else n_pass++;
    tick();
    n_checks++; if (mif.imem_req !== 1'b1 || mif.imem_addr !== 32'h100 || id_valid !== 1'b0)
      $display("FAIL drop_redirect got req=%b addr=%h v=%b exp req=1 addr=100 v=0", mif.imem_req, mif.imem_addr, id_valid);
    else n_pass++;
    ack_man = 1'b1; rdata_man = 32'h1111_2222;
    tick();
    ack_man = 1'b0;
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_inst !== 32'h1111_2222)
      $display("FAIL drop_newdata got v=%b pc=%h inst=%h exp v=1 pc=100 inst=11112222", id_valid, id_pc, id_inst);
    else n_pass++;
    $display("test_flush_drop done");
  endtask

  task automatic test_flush_ack_pop();
    zw = 1'b1; bbl = 1'b0; flush = 1'b0; ack_man = 1'b0;
    do_reset();
    tick();  // WAIT
    tick();  // one entry queued, next ack pending
    flush = 1'b1; flush_pc = 32'h0000_0103;
    tick();  // flush + ack + pop together
    flush = 1'b0; zw = 1'b0;
    n_checks++; if (id_valid !== 1'b0 || stop !== 1'b1 || mif.imem_req !== 1'b0)
      $display("FAIL fap_empty got v=%b stop=%b req=%b exp v=0 stop=1 req=0", id_valid, stop, mif.imem_req);
    else n_pass++;
    tick();
    n_checks++; if (mif.imem_req !== 1'b1 || mif.imem_addr !== 32'h100)
      $display("FAIL fap_addr got req=%b addr=%h exp req=1 addr=100", mif.imem_req, mif.imem_addr);
    else n_pass++;
    $display("test_flush_ack_pop done");
  endtask

  task automatic test_wrap_reset();
    zw = 1'b0; ack_man = 1'b0; bbl = 1'b0; flush = 1'b0;
    do_reset();
    flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
    tick();  // redirect while IDLE
    flush = 1'b0; zw = 1'b1;
    tick();
    n_checks++; if (mif.imem_req !== 1'b1 || mif.imem_addr !== 32'hFFFF_FFFC)
      $display("FAIL wrap_addr0 got req=%b addr=%h exp req=1 addr=fffffffc", mif.imem_req, mif.imem_addr);
    else n_pass++;
    tick();
    n_checks++; if (mif.imem_addr !== 32'h0 || id_pc !== 32'hFFFF_FFFC || id_inst !== 32'h0FFF_FFFC)
      $display("FAIL wrap_addr1 got addr=%h pc=%h inst=%h exp addr=0 pc=fffffffc inst=0ffffffc",
               mif.imem_addr, id_pc, id_inst);
    else n_pass++;
    tick();
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_inst !== 32'h1000_0000)
      $display("FAIL wrap_data got v=%b pc=%h inst=%h exp v=1 pc=0 inst=10000000", id_valid, id_pc, id_inst);
    else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++;
    if (mif.imem_req !== 1'b0 || id_valid !== 1'b0 || id_pc !== 32'h0 || id_inst !== 32'h0 || stop !== 1'b1)
      $display("FAIL midreset got req=%b v=%b pc=%h inst=%h stop=%b exp req=0 v=0 pc=0 inst=0 stop=1",
               mif.imem_req, id_valid, id_pc, id_inst, stop);
    else n_pass++;
    rst = 1'b1;
    $display("test_wrap_reset done");
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_stream();
    test_bbl();
    test_flush_drop();
    test_flush_ack_pop();
    test_wrap_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
